// File: rtl/nock_increment_pkg.sv
// Shared constants for the Nock opcode units: word layout, tag bits, memory functions, return codes.
// The FSM encoding includes the FREE states only when NOCK_INC_FREE_EN is defined.
package nock_increment_pkg;

   localparam int ADDR_W_DEF = 11;
   localparam int NOUN_W_DEF = 28;
   localparam int TAG_W_DEF  = 8;

   // Word is {tag, hed, tel}; tag bit set means that slot holds a pointer to a cell.
   localparam int TAG_TEL_CELL  = 0;
   localparam int TAG_HED_CELL  = 1;
   localparam int TAG_EXECUTE   = 7;
   localparam int TAG_ATOM_ATOM = 0;

   localparam logic [1:0] MEM_IDLE     = 2'd0;
   localparam logic [1:0] GET_CONTENTS = 2'd1;
   localparam logic [1:0] SET_CONTENTS = 2'd2;

   localparam logic [3:0] SYS_FUNC_TRAVERSE = 4'h2;
   localparam logic [3:0] SYS_FUNC_EXECUTE  = 4'h3;
   localparam logic [3:0] SYS_TRAVERSE_POP  = 4'h2;
   localparam logic [3:0] SYS_EXECUTE_ERROR = 4'hF;

   localparam logic [7:0] ERR_NONE     = 8'h00;
   localparam logic [7:0] ERR_B_CELL   = 8'h41;
   localparam logic [7:0] ERR_OVERFLOW = 8'h42;
   localparam logic [7:0] ERR_NO_MATCH = 8'h43;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CHECK,
      ST_RD_PAR,
      ST_RD_WAIT,
      ST_MATCH,
      ST_ROOT,
      ST_WR,
      ST_WR_WAIT,
`ifdef NOCK_INC_FREE_EN
      ST_FREE,
      ST_FREE_WAIT,
`endif
      ST_DONE,
      ST_ERR
   } inc_state_t;

endpackage

// File: rtl/nock_increment_mem_port.sv
// Single-request memory port: one-cycle strobe, then waits for the first mem_ready.
// Reusable by the sibling opcode units; module name nock_mem_port.
module nock_mem_port
   import nock_increment_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = TAG_W_DEF + 2 * NOUN_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [1:0]        req_func,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              mem_ready,
   output logic              mem_execute,
   output logic [ADDR_W-1:0] address1,
   output logic [1:0]        mem_func,
   output logic [DATA_W-1:0] write_data,
   output logic              done
);

   logic pending;

   // A ready that arrives with no request outstanding is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
      end else if (req) begin
         pending <= 1'b1;
      end else if (mem_ready) begin
         pending <= 1'b0;
      end
   end

   assign done        = pending & mem_ready;
   assign mem_execute = req;
   assign mem_func    = req ? req_func : MEM_IDLE;
   assign address1    = req_addr;
   assign write_data  = req ? req_wdata : '0;

endmodule

// File: rtl/nock_increment.sv
// Nock opcode 4 unit: increments atom b of node [4 b] and splices the result into the parent.
// Define NOCK_INC_FREE_EN to zero the consumed node after the parent write.
module nock_increment
   import nock_increment_pkg::*;
#(
   parameter int  ADDR_W = ADDR_W_DEF,
   parameter int  NOUN_W = NOUN_W_DEF,
   parameter int  TAG_W  = TAG_W_DEF,
   localparam int DATA_W = TAG_W + 2 * NOUN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] node_addr,
   input  logic [DATA_W-1:0] node_data,
   input  logic [ADDR_W-1:0] parent_addr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] read_data1,
   output logic              mem_execute,
   output logic [ADDR_W-1:0] address1,
   output logic [1:0]        mem_func,
   output logic [DATA_W-1:0] write_data,
   output logic              module_finished,
   output logic [ADDR_W-1:0] ret_address,
   output logic [3:0]        ret_sys_func,
   output logic [3:0]        ret_state,
   output logic [7:0]        error
);

   localparam int HED_LO = NOUN_W;
   localparam int TAG_LO = 2 * NOUN_W;
   localparam logic [ADDR_W-1:0] NIL = '1;

   inc_state_t        state, next_state;
   logic [ADDR_W-1:0] node_addr_q, parent_addr_q, wr_addr;
   logic              node_tel_cell_q, root_q;
   logic [NOUN_W-1:0] node_tel_q, result_q, result_c;
   logic [DATA_W-1:0] parent_word_q, wr_word_q, match_word;
   logic [TAG_W-1:0]  par_tag;
   logic [NOUN_W-1:0] par_hed, par_tel;
   logic              req, mem_done;
   logic [1:0]        req_func;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [7:0]        err_code;
   logic              node_data_unused;

   assign node_data_unused = ^{node_data[DATA_W-1:TAG_LO+1], node_data[TAG_LO-1:HED_LO]};
   assign result_c = node_tel_q + NOUN_W'(1);
   assign par_tag  = parent_word_q[DATA_W-1:TAG_LO];
   assign par_hed  = parent_word_q[TAG_LO-1:HED_LO];
   assign par_tel  = parent_word_q[NOUN_W-1:0];
   assign wr_addr  = root_q ? node_addr_q : parent_addr_q;
   assign module_finished = (state == ST_DONE) || (state == ST_ERR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and memory request decode; the root case reuses the write/wait path.
   always_comb begin
      next_state = state;
      req        = 1'b0;
      req_func   = MEM_IDLE;
      req_addr   = '0;
      req_wdata  = '0;
      err_code   = ERR_NONE;
      match_word = parent_word_q;
      case (state)
         ST_IDLE: begin
            if (start) next_state = ST_CHECK;
         end
         ST_CHECK: begin
            if (node_tel_cell_q) begin
               err_code   = ERR_B_CELL;
               next_state = ST_ERR;
            end else if (&node_tel_q) begin
               err_code   = ERR_OVERFLOW;
               next_state = ST_ERR;
            end else if (parent_addr_q == NIL) begin
               next_state = ST_ROOT;
            end else begin
               next_state = ST_RD_PAR;
            end
         end
         ST_RD_PAR: begin
            req        = 1'b1;
            req_func   = GET_CONTENTS;
            req_addr   = parent_addr_q;
            next_state = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            req_addr = parent_addr_q;
            if (mem_done) next_state = ST_MATCH;
         end
         ST_MATCH: begin
            if (par_hed == NOUN_W'(node_addr_q) && par_tag[TAG_HED_CELL]) begin
               match_word[TAG_LO+TAG_HED_CELL] = 1'b0;
               match_word[TAG_LO-1:HED_LO]     = result_q;
               next_state = ST_WR;
            end else if (par_tel == NOUN_W'(node_addr_q) && par_tag[TAG_TEL_CELL]) begin
               match_word[TAG_LO+TAG_TEL_CELL] = 1'b0;
               match_word[NOUN_W-1:0]          = result_q;
               next_state = ST_WR;
            end else begin
               err_code   = ERR_NO_MATCH;
               next_state = ST_ERR;
            end
         end
         ST_ROOT, ST_WR: begin
            req        = 1'b1;
            req_func   = SET_CONTENTS;
            req_addr   = wr_addr;
            req_wdata  = wr_word_q;
            next_state = ST_WR_WAIT;
         end
         ST_WR_WAIT: begin
            req_addr = wr_addr;
            if (mem_done) begin
`ifdef NOCK_INC_FREE_EN
               next_state = root_q ? ST_DONE : ST_FREE;
`else
               next_state = ST_DONE;
`endif
            end
         end
`ifdef NOCK_INC_FREE_EN
         ST_FREE: begin
            req        = 1'b1;
            req_func   = SET_CONTENTS;
            req_addr   = node_addr_q;
            next_state = ST_FREE_WAIT;
         end
         ST_FREE_WAIT: begin
            req_addr = node_addr_q;
            if (mem_done) next_state = ST_DONE;
         end
`endif
         ST_DONE, ST_ERR: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Operand capture; the root word is prepared in CHECK so ROOT can write it directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         node_addr_q     <= '0;
         parent_addr_q   <= '0;
         node_tel_cell_q <= 1'b0;
         node_tel_q      <= '0;
         result_q        <= '0;
         root_q          <= 1'b0;
         parent_word_q   <= '0;
         wr_word_q       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  node_addr_q     <= node_addr;
                  parent_addr_q   <= parent_addr;
                  node_tel_cell_q <= node_data[TAG_LO+TAG_TEL_CELL];
                  node_tel_q      <= node_data[NOUN_W-1:0];
               end
            end
            ST_CHECK: begin
               result_q  <= result_c;
               root_q    <= (parent_addr_q == NIL);
               wr_word_q <= {TAG_W'(TAG_ATOM_ATOM), result_c, {NOUN_W{1'b0}}};
            end
            ST_RD_WAIT: begin
               if (mem_done) parent_word_q <= read_data1;
            end
            ST_MATCH: begin
               wr_word_q <= match_word;
            end
            default: begin
            end
         endcase
      end
   end

   // Return codes are loaded on the way into DONE/ERR and held until the next start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ret_address  <= '0;
         ret_sys_func <= 4'h0;
         ret_state    <= 4'h0;
         error        <= ERR_NONE;
      end else if (state == ST_IDLE && start) begin
         ret_address  <= '0;
         ret_sys_func <= 4'h0;
         ret_state    <= 4'h0;
         error        <= ERR_NONE;
      end else if (next_state == ST_DONE) begin
         ret_address  <= wr_addr;
         ret_sys_func <= SYS_FUNC_TRAVERSE;
         ret_state    <= SYS_TRAVERSE_POP;
         error        <= ERR_NONE;
      end else if (next_state == ST_ERR) begin
         ret_address  <= node_addr_q;
         ret_sys_func <= SYS_FUNC_EXECUTE;
         ret_state    <= SYS_EXECUTE_ERROR;
         error        <= err_code;
      end
   end

   nock_mem_port #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_mem_port (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_func   (req_func),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .mem_ready  (mem_ready),
      .mem_execute(mem_execute),
      .address1   (address1),
      .mem_func   (mem_func),
      .write_data (write_data),
      .done       (mem_done)
   );

endmodule

// File: tb/tb_nock_increment.sv
// Directed bench for nock_increment with a behavioural memory that answers after ready_delay cycles.
// Expectations adapt when NOCK_INC_FREE_EN is defined.
module tb_nock_increment;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 64;
   localparam logic [1:0] F_GET = 2'd1;
   localparam logic [1:0] F_SET = 2'd2;
`ifdef NOCK_INC_FREE_EN
   localparam int FREE_EN = 1;
`else
   localparam int FREE_EN = 0;
`endif

   logic              clk, rst, start, mem_ready;
   logic [ADDR_W-1:0] node_addr, parent_addr, address1, ret_address;
   logic [DATA_W-1:0] node_data, read_data1, write_data;
   logic              mem_execute, module_finished;
   logic [1:0]        mem_func;
   logic [3:0]        ret_sys_func, ret_state;
   logic [7:0]        error;

   logic [DATA_W-1:0] mem [0:2047];
   logic [ADDR_W-1:0] pend_addr;
   int checks, errors, rd_count, wr_count, ready_delay, cd, lat, r0, w0;

   nock_increment dut (
      .clk(clk), .rst(rst), .start(start), .node_addr(node_addr), .node_data(node_data),
      .parent_addr(parent_addr), .mem_ready(mem_ready), .read_data1(read_data1),
      .mem_execute(mem_execute), .address1(address1), .mem_func(mem_func),
      .write_data(write_data), .module_finished(module_finished), .ret_address(ret_address),
      .ret_sys_func(ret_sys_func), .ret_state(ret_state), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: a strobe seen on one falling edge is answered ready_delay falling edges later.
   always @(negedge clk) begin
      if (rst) begin
         cd        = 0;
         mem_ready = 1'b0;
      end else begin
         mem_ready = 1'b0;
         if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
               mem_ready  = 1'b1;
               read_data1 = mem[pend_addr];
            end
         end
         if (mem_execute) begin
            pend_addr = address1;
            if (mem_func == F_SET) begin
               mem[address1] = write_data;
               wr_count = wr_count + 1;
            end else begin
               rd_count = rd_count + 1;
            end
            cd = ready_delay;
         end
      end
   end

   function automatic logic [63:0] mk(input logic [7:0] t, input logic [27:0] h, input logic [27:0] l);
      return {t, h, l};
   endfunction

   // Issues one start and returns with lat = cycle (start cycle = 1) on which module_finished is seen.
   task automatic run_op(input logic [10:0] na, input logic [63:0] nd, input logic [10:0] pa,
                         input bit glitch);
      @(negedge clk);
      node_addr = na; node_data = nd; parent_addr = pa; start = 1'b1;
      r0 = rd_count; w0 = wr_count;
      @(negedge clk);
      start = 1'b0;
      lat = 2;
      while (!module_finished && lat < 100) begin
         @(negedge clk);
         lat = lat + 1;
         if (glitch && lat == 4) begin
            start = 1'b1; node_addr = 11'd5; parent_addr = 11'h7FF; node_data = '0;
         end else begin
            start = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; node_addr = '0; node_data = '0; parent_addr = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({mem_execute, mem_func, address1, write_data, module_finished} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mem_if: got exec=%b func=%0d addr=%0d wd=%h fin=%b required all 0",
                  mem_execute, mem_func, address1, write_data, module_finished);
      end
      checks++;
      if ({ret_address, ret_sys_func, ret_state, error} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_ret: got addr=%0d sf=%h st=%h err=%h required all 0",
                  ret_address, ret_sys_func, ret_state, error);
      end
      rst = 1'b0;
   endtask

   task automatic test_hed_match();
      mem[10] = mk(8'h8E, 28'd20, 28'd33);
      mem[20] = mk(8'h00, 28'd4, 28'd5);
      run_op(11'd20, mk(8'h00, 28'd4, 28'd5), 11'd10, 1'b0);
      checks++;
      if (lat !== 8 + 2 * FREE_EN) begin
         errors++; $display("[TB] FAIL hed_latency: got %0d required %0d", lat, 8 + 2 * FREE_EN);
      end
      checks++;
      if ({ret_address, ret_sys_func, ret_state, error} !== {11'd10, 4'h2, 4'h2, 8'h00}) begin
         errors++;
         $display("[TB] FAIL hed_ret: got addr=%0d sf=%h st=%h err=%h required 10/2/2/00",
                  ret_address, ret_sys_func, ret_state, error);
      end
      checks++;
      if (mem[10] !== mk(8'h8C, 28'd6, 28'd33)) begin
         errors++; $display("[TB] FAIL hed_parent: got %h required %h", mem[10], mk(8'h8C, 28'd6, 28'd33));
      end
      checks++;
      if (rd_count - r0 !== 1 || wr_count - w0 !== 1 + FREE_EN) begin
         errors++;
         $display("[TB] FAIL hed_accesses: got rd=%0d wr=%0d required rd=1 wr=%0d",
                  rd_count - r0, wr_count - w0, 1 + FREE_EN);
      end
      checks++;
      if (mem[20] !== (FREE_EN != 0 ? 64'h0 : mk(8'h00, 28'd4, 28'd5))) begin
         errors++; $display("[TB] FAIL hed_node_word: got %h", mem[20]);
      end
      @(negedge clk);
      checks++;
      if (module_finished !== 1'b0) begin
         errors++; $display("[TB] FAIL hed_pulse_width: got finished=%b required 0", module_finished);
      end
   endtask

   task automatic test_tel_match();
      mem[11] = mk(8'h85, 28'd99, 28'd20);
      run_op(11'd20, mk(8'h00, 28'd4, 28'd5), 11'd11, 1'b0);
      checks++;
      if (mem[11] !== mk(8'h84, 28'd99, 28'd6) || ret_address !== 11'd11) begin
         errors++;
         $display("[TB] FAIL tel_parent: got %h ret=%0d required %h ret=11",
                  mem[11], ret_address, mk(8'h84, 28'd99, 28'd6));
      end
      // hed holds the address value but is an atom, so only the tel slot qualifies
      mem[12] = mk(8'h01, 28'd20, 28'd20);
      run_op(11'd20, mk(8'h00, 28'd4, 28'd5), 11'd12, 1'b0);
      checks++;
      if (mem[12] !== mk(8'h00, 28'd20, 28'd6)) begin
         errors++; $display("[TB] FAIL tel_only_cell: got %h required %h", mem[12], mk(8'h00, 28'd20, 28'd6));
      end
      mem[13] = mk(8'h03, 28'd20, 28'd20);
      run_op(11'd20, mk(8'h00, 28'd4, 28'd5), 11'd13, 1'b0);
      checks++;
      if (mem[13] !== mk(8'h01, 28'd6, 28'd20)) begin
         errors++; $display("[TB] FAIL hed_first: got %h required %h", mem[13], mk(8'h01, 28'd6, 28'd20));
      end
   endtask

   task automatic test_overflow();
      run_op(11'd20, mk(8'h00, 28'd4, 28'hFFFFFFF), 11'd10, 1'b0);
      checks++;
      if (lat !== 3 || error !== 8'h42 || ret_sys_func !== 4'h3 || ret_state !== 4'hF) begin
         errors++;
         $display("[TB] FAIL overflow: got lat=%0d err=%h sf=%h st=%h required 3/42/3/F",
                  lat, error, ret_sys_func, ret_state);
      end
      checks++;
      if (rd_count != r0 || wr_count != w0) begin
         errors++; $display("[TB] FAIL overflow_no_mem: got rd=%0d wr=%0d required 0/0", rd_count - r0, wr_count - w0);
      end
      @(negedge clk);
      checks++;
      if (module_finished !== 1'b0 || error !== 8'h42) begin
         errors++; $display("[TB] FAIL overflow_hold: got fin=%b err=%h required 0/42", module_finished, error);
      end
   endtask

   task automatic test_errors();
      run_op(11'd20, mk(8'h01, 28'd4, 28'd40), 11'd10, 1'b0);
      checks++;
      if (lat !== 3 || error !== 8'h41) begin
         errors++; $display("[TB] FAIL b_cell: got lat=%0d err=%h required 3/41", lat, error);
      end
      mem[14] = mk(8'h03, 28'd7, 28'd8);
      run_op(11'd20, mk(8'h00, 28'd4, 28'd5), 11'd14, 1'b0);
      checks++;
      if (lat !== 6 || error !== 8'h43 || ret_state !== 4'hF) begin
         errors++; $display("[TB] FAIL no_match: got lat=%0d err=%h st=%h required 6/43/F", lat, error, ret_state);
      end
      checks++;
      if (rd_count - r0 !== 1 || wr_count != w0 || mem[14] !== mk(8'h03, 28'd7, 28'd8)) begin
         errors++; $display("[TB] FAIL no_match_mem: got rd=%0d wr=%0d word=%h", rd_count - r0, wr_count - w0, mem[14]);
      end
   endtask

   task automatic test_root();
      mem[30] = mk(8'h80, 28'd4, 28'd0);
      run_op(11'd30, mk(8'h80, 28'd4, 28'd0), 11'h7FF, 1'b0);
      checks++;
      if (lat !== 5 || ret_address !== 11'd30 || ret_sys_func !== 4'h2 || ret_state !== 4'h2) begin
         errors++;
         $display("[TB] FAIL root_ret: got lat=%0d addr=%0d sf=%h st=%h required 5/30/2/2",
                  lat, ret_address, ret_sys_func, ret_state);
      end
      checks++;
      if (mem[30] !== mk(8'h00, 28'd1, 28'd0) || rd_count != r0 || wr_count - w0 !== 1) begin
         errors++;
         $display("[TB] FAIL root_write: got %h rd=%0d wr=%0d required %h rd=0 wr=1",
                  mem[30], rd_count - r0, wr_count - w0, mk(8'h00, 28'd1, 28'd0));
      end
   endtask

   task automatic test_reset_mid_op();
      mem[10] = mk(8'h8E, 28'd20, 28'd33);
      @(negedge clk);
      node_addr = 11'd20; node_data = mk(8'h00, 28'd4, 28'd9); parent_addr = 11'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_execute !== 1'b1 || mem_func !== F_GET || address1 !== 11'd10) begin
         errors++; $display("[TB] FAIL rd_strobe: got exec=%b func=%0d addr=%0d required 1/1/10", mem_execute, mem_func, address1);
      end
      @(negedge clk);
      checks++;
      if (mem_execute !== 1'b0 || mem_func !== 2'd0) begin
         errors++; $display("[TB] FAIL rd_wait_idle: got exec=%b func=%0d required 0/0", mem_execute, mem_func);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({mem_execute, mem_func, address1, module_finished, ret_address, error} !== '0) begin
         errors++;
         $display("[TB] FAIL async_reset: got exec=%b func=%0d addr=%0d fin=%b ret=%0d err=%h required all 0",
                  mem_execute, mem_func, address1, module_finished, ret_address, error);
      end
      @(negedge clk);
      rst = 1'b0;
      mem[15] = mk(8'h8E, 28'd21, 28'd1);
      run_op(11'd21, mk(8'h00, 28'd4, 28'd100), 11'd15, 1'b0);
      checks++;
      if (lat !== 8 + 2 * FREE_EN || mem[15] !== mk(8'h8C, 28'd101, 28'd1) || mem[10] !== mk(8'h8E, 28'd20, 28'd33)) begin
         errors++;
         $display("[TB] FAIL after_reset: got lat=%0d p15=%h p10=%h required lat=%0d p15=%h",
                  lat, mem[15], mem[10], 8 + 2 * FREE_EN, mk(8'h8C, 28'd101, 28'd1));
      end
   endtask

   task automatic test_back_to_back();
      ready_delay = 3;
      mem[16] = mk(8'h0D, 28'd55, 28'd22);
      run_op(11'd22, mk(8'h00, 28'd4, 28'h0ABCDEF), 11'd16, 1'b1);
      checks++;
      if (lat !== 12 + 4 * FREE_EN || mem[16] !== mk(8'h0C, 28'd55, 28'h0ABCDF0) || ret_address !== 11'd16) begin
         errors++;
         $display("[TB] FAIL slow_mem: got lat=%0d word=%h ret=%0d required lat=%0d word=%h ret=16",
                  lat, mem[16], ret_address, 12 + 4 * FREE_EN, mk(8'h0C, 28'd55, 28'h0ABCDF0));
      end
      ready_delay = 1;
      mem[17] = mk(8'h02, 28'd23, 28'd0);
      run_op(11'd23, mk(8'h00, 28'd4, 28'd77), 11'd17, 1'b0);
      checks++;
      if (lat !== 8 + 2 * FREE_EN || mem[17] !== mk(8'h00, 28'd78, 28'd0)) begin
         errors++; $display("[TB] FAIL back_to_back: got lat=%0d word=%h required %h", lat, mem[17], mk(8'h00, 28'd78, 28'd0));
      end
   endtask

   initial begin
      checks = 0; errors = 0; rd_count = 0; wr_count = 0; ready_delay = 1; cd = 0;
      mem_ready = 1'b0; read_data1 = '0; pend_addr = '0;
      for (int i = 0; i < 2048; i++) mem[i] = '0;
      test_reset();
      test_hed_match();
      test_tel_match();
      test_overflow();
      test_errors();
      test_root();
      test_reset_mid_op();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
